// File: rtl/prach_hb5_interp_if.sv
// Sample bus for the PRACH hb5 x2 interpolator.
// One TDM slot per clock in, two polyphase samples per slot out.
interface prach_hb5_interp_if;
   logic signed [15:0] din_dq;
   logic        [7:0]  din_chn;
   logic               sync_in;
   logic signed [15:0] dout_dp1;
   logic signed [15:0] dout_dp2;
   logic        [7:0]  dout_chn;
   logic               sync_out;

   modport master (
      output din_dq, din_chn, sync_in,
      input  dout_dp1, dout_dp2, dout_chn, sync_out
   );

   modport slave (
      input  din_dq, din_chn, sync_in,
      output dout_dp1, dout_dp2, dout_chn, sync_out
   );
endinterface

// File: rtl/prach_hb5_interp.sv
// Half-band x2 interpolator, 48 of 256 TDM channels, 6-cycle latency.
// Define PRACH_HB5_INTERP_SAT_EN to saturate dp2 instead of wrapping.
module prach_hb5_interp (
   input  logic clk,
   input  logic rst_n,
   prach_hb5_interp_if.slave bus
);
   localparam int NUM_CHANNEL_USED = 48;
   localparam int LATENCY          = 6;
   localparam int LINE_LEN         = 337;
   localparam int TAP_STEP         = 48;

   localparam logic signed [17:0] C [4] = '{
      -18'sd616, 18'sd2989, -18'sd9818, 18'sd40178
   };

   logic signed [15:0] r_xq [LINE_LEN];
   logic signed [15:0] w_tap [8];
   logic               w_act;

   logic signed [15:0] r_tap  [8];
   logic signed [16:0] r_pre  [4];
   logic signed [34:0] r_prod [4];
   logic signed [35:0] r_ps   [2];
   logic signed [36:0] r_acc;
   logic signed [15:0] r_d1   [5];
   logic        [4:0]  r_act;
   logic        [5:0]  r_sync;
   logic signed [15:0] r_dp1;
   logic signed [15:0] r_dp2;
   logic        [7:0]  r_chn;

   logic signed [36:0] w_rnd;
   logic signed [15:0] w_dp2;
   logic               w_unused;

   assign w_act = bus.din_chn < 8'(NUM_CHANNEL_USED);

   always_ff @(posedge clk) begin
      if (w_act) begin
         r_xq[0] <= bus.din_dq;
         for (int i = 1; i < LINE_LEN; i++)
            r_xq[i] <= r_xq[i-1];
      end
   end

   // Taps as the line will stand after this slot's shift.
   always_comb begin
      for (int k = 0; k < 8; k++)
         w_tap[k] = r_xq[k*TAP_STEP];
      if (w_act) begin
         w_tap[0] = bus.din_dq;
         for (int k = 1; k < 8; k++)
            w_tap[k] = r_xq[k*TAP_STEP-1];
      end
   end

   assign w_rnd = r_acc + 37'sd32768;

`ifdef PRACH_HB5_INTERP_SAT_EN
   logic signed [20:0] w_q;
   assign w_q = $signed(w_rnd[36:16]);
   always_comb begin
      if (w_q > 21'sd32767)
         w_dp2 = 16'sh7fff;
      else if (w_q < -21'sd32768)
         w_dp2 = 16'sh8000;
      else
         w_dp2 = w_q[15:0];
   end
   assign w_unused = ^w_rnd[15:0];
`else
   assign w_dp2    = w_rnd[31:16];
   assign w_unused = ^{w_rnd[36:32], w_rnd[15:0]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) r_tap[k] <= '0;
         for (int k = 0; k < 4; k++) begin
            r_pre[k]  <= '0;
            r_prod[k] <= '0;
         end
         for (int k = 0; k < 5; k++) r_d1[k] <= '0;
         r_ps[0] <= '0;
         r_ps[1] <= '0;
         r_acc   <= '0;
         r_act   <= '0;
         r_sync  <= '0;
         r_dp1   <= '0;
         r_dp2   <= '0;
         r_chn   <= '0;
      end else begin
         for (int k = 0; k < 8; k++) r_tap[k] <= w_tap[k];
         for (int k = 0; k < 4; k++) begin
            r_pre[k]  <= 17'(r_tap[k]) + 17'(r_tap[7-k]);
            r_prod[k] <= 35'(r_pre[k]) * 35'(C[k]);
         end
         r_ps[0] <= 36'(r_prod[0]) + 36'(r_prod[1]);
         r_ps[1] <= 36'(r_prod[2]) + 36'(r_prod[3]);
         r_acc   <= 37'(r_ps[0]) + 37'(r_ps[1]);
         r_d1[0] <= w_tap[4];
         for (int k = 1; k < 5; k++) r_d1[k] <= r_d1[k-1];
         r_act   <= {r_act[3:0], w_act};
         r_sync  <= {r_sync[4:0], bus.sync_in};
         r_dp1   <= r_act[4] ? r_d1[4] : 16'sd0;
         r_dp2   <= r_act[4] ? w_dp2 : 16'sd0;
         // Slot index assumes consecutive channel numbering.
         r_chn   <= bus.din_chn - 8'(LATENCY - 1);
      end
   end

   assign bus.dout_dp1 = r_dp1;
   assign bus.dout_dp2 = r_dp2;
   assign bus.dout_chn = r_chn;
   assign bus.sync_out = r_sync[5];
endmodule

// File: tb/tb_prach_hb5_interp.sv
// Randomised bench for prach_hb5_interp against a queue-based model
// of the shared delay line; spec vectors checked as constants.
module tb_prach_hb5_interp;
   typedef struct {
      logic signed [15:0] dp1;
      logic signed [15:0] dp2;
      logic        [7:0]  chn;
      logic               sync;
      logic        [7:0]  ichn;
      int                 tag;
   } smp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   prach_hb5_interp_if bus();
   prach_hb5_interp dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic signed [15:0] line [$];
   smp_t pipe [$];
   logic [7:0] exp_ochn = 8'd0;
   int cur_tag = 0;
   int checks = 0;
   int passed = 0;

   function automatic smp_t zero_smp();
      smp_t z;
      z.dp1 = 0; z.dp2 = 0; z.chn = 0;
      z.sync = 0; z.ichn = 0; z.tag = cur_tag;
      return z;
   endfunction

   function automatic logic signed [15:0] model_dp2();
      longint c [4] = '{-616, 2989, -9818, 40178};
      longint acc = 0;
      longint q;
      logic [63:0] v;
      for (int k = 0; k < 4; k++)
         acc += c[k] * (longint'(line[48*k]) + longint'(line[48*(7-k)]));
      acc += 32768;
      q = acc >>> 16;
`ifdef PRACH_HB5_INTERP_SAT_EN
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      v = q;
      return v[15:0];
`else
      v = acc;
      return v[31:16];
`endif
   endfunction

   task automatic step(input logic [7:0] chn, input logic signed [15:0] dq,
                       input logic sy, output smp_t o, output smp_t e);
      smp_t n;
      @(negedge clk);
      o = zero_smp();
      o.dp1 = bus.dout_dp1; o.dp2 = bus.dout_dp2;
      o.chn = bus.dout_chn; o.sync = bus.sync_out;
      e = pipe.pop_front();
      e.chn = exp_ochn;
      bus.din_chn = chn; bus.din_dq = dq; bus.sync_in = sy;
      if (chn < 8'd48) begin
         line.push_front(dq);
         void'(line.pop_back());
      end
      n = zero_smp();
      n.ichn = chn;
      if (rst_n) begin
         n.sync = sy;
         if (chn < 8'd48) begin
            n.dp1 = line[192];
            n.dp2 = model_dp2();
         end
      end
      pipe.push_back(n);
      exp_ochn = rst_n ? chn - 8'd5 : 8'd0;
   endtask

   task automatic test_reset();
      smp_t o, e;
      for (int i = 0; i < 4; i++) begin
         step(8'd255, 16'sd0, 1'b0, o, e);
         checks++;
         if ({o.dp1, o.dp2, o.chn, o.sync} !== 41'd0)
            $display("FAIL reset_state: got dp1=%0d dp2=%0d chn=%0d sync=%0d want 0",
                     o.dp1, o.dp2, o.chn, o.sync);
         else passed++;
      end
      @(posedge clk); #1 rst_n = 1'b1;
      for (int n = 0; n < 9*256; n++) begin
         step(8'(n % 256), 16'sd0, 1'b0, o, e);
         checks++;
         if (o.chn !== e.chn || o.sync !== e.sync)
            $display("FAIL flush_chn: got chn=%0d sync=%0d want chn=%0d sync=%0d",
                     o.chn, o.sync, e.chn, e.sync);
         else passed++;
      end
   endtask

   task automatic test_impulse();
      smp_t o, e;
      int k = 0;
      int exp2 [8] = '{-154, 747, -2454, 10045, 10045, -2454, 747, -154};
      int w1, w2;
      cur_tag = 1;
      for (int n = 0; n < 10*256; n++) begin
         step(8'(n % 256), (n == 0) ? 16'sd16384 : 16'sd0, 1'b0, o, e);
         if (e.tag == 1) begin
            w1 = 0; w2 = 0;
            if (e.ichn == 0 && k < 8) begin
               w2 = exp2[k];
               w1 = (k == 4) ? 16384 : 0;
               k++;
            end
            checks++;
            if (o.dp1 !== w1 || o.dp2 !== w2 || o.chn !== e.chn)
               $display("FAIL impulse ch%0d: got dp1=%0d dp2=%0d chn=%0d want dp1=%0d dp2=%0d chn=%0d",
                        e.ichn, o.dp1, o.dp2, o.chn, w1, w2, e.chn);
            else passed++;
         end
      end
      checks++;
      if (k != 8) $display("FAIL impulse_count: got %0d ch0 slots want 8", k);
      else passed++;
   endtask

   task automatic test_dc();
      smp_t o, e;
      int c, w1, w2;
      for (int n = 0; n < 9*256 + 6; n++) begin
         c = n % 256;
         cur_tag = 20 + n / 256;
         step(8'(c), (c < 48) ? 16'sd32767 : 16'($urandom), 1'b0, o, e);
         if (e.tag == 28) begin
            w1 = (e.ichn < 48) ? 32767 : 0;
            w2 = (e.ichn < 48) ? 32732 : 0;
            checks++;
            if (o.dp1 !== w1 || o.dp2 !== w2)
               $display("FAIL dc ch%0d: got dp1=%0d dp2=%0d want dp1=%0d dp2=%0d",
                        e.ichn, o.dp1, o.dp2, w1, w2);
            else passed++;
         end
      end
   endtask

   task automatic test_sat();
      smp_t o, e;
      logic signed [15:0] v [8] = '{-16'sd32768, 16'sd32767, -16'sd32768, 16'sd32767,
                                     16'sd32767, -16'sd32768, 16'sd32767, -16'sd32768};
`ifdef PRACH_HB5_INTERP_SAT_EN
      int want = 32767;
`else
      int want = -11936;
`endif
      int c, f;
      for (int n = 0; n < 8*256 + 6; n++) begin
         c = n % 256;
         f = n / 256;
         cur_tag = 30 + f;
         step(8'(c), (c == 0 && f < 8) ? v[f] : 16'sd0, 1'b0, o, e);
         if (e.tag >= 30) begin
            checks++;
            if (o.dp1 !== e.dp1 || o.dp2 !== e.dp2)
               $display("FAIL sat_model ch%0d: got dp1=%0d dp2=%0d want dp1=%0d dp2=%0d",
                        e.ichn, o.dp1, o.dp2, e.dp1, e.dp2);
            else passed++;
         end
         if (e.tag == 37 && e.ichn == 0) begin
            checks++;
            if (o.dp2 !== want)
               $display("FAIL sat_limit: got dp2=%0d want %0d", o.dp2, want);
            else passed++;
         end
      end
   endtask

   task automatic test_gating();
      smp_t o, e;
      int c;
      logic signed [15:0] dq;
      cur_tag = 40;
      for (int n = 0; n < 4*256 + 6; n++) begin
         c = n % 256;
         dq = (n < 256) ? 16'(c) : 16'($urandom);
         step(8'(c), dq, ($urandom_range(0, 15) == 0), o, e);
         if (e.tag == 40) begin
            checks++;
            if (o.dp1 !== e.dp1 || o.dp2 !== e.dp2 || o.chn !== e.chn ||
                o.sync !== e.sync)
               $display("FAIL gating ch%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                        e.ichn, o.dp1, o.dp2, o.chn, o.sync,
                        e.dp1, e.dp2, e.chn, e.sync);
            else passed++;
         end
      end
   endtask

   task automatic test_sync();
      smp_t o, e;
      int seen = 0;
      cur_tag = 50;
      for (int n = 0; n < 50; n++) begin
         step(8'(n + 100), 16'sd0, (n == 7 || n == 20 || n == 21), o, e);
         if (e.tag == 50) begin
            seen += o.sync;
            checks++;
            if (o.sync !== e.sync || o.chn !== e.chn)
               $display("FAIL sync n=%0d: got sync=%0d chn=%0d want sync=%0d chn=%0d",
                        n, o.sync, o.chn, e.sync, e.chn);
            else passed++;
         end
      end
      checks++;
      if (seen != 3) $display("FAIL sync_count: got %0d pulses want 3", seen);
      else passed++;
   endtask

   task automatic test_reset_mid();
      smp_t o, e;
      int c;
      cur_tag = 60;
      for (int n = 0; n <= 20; n++)
         step(8'(n), 16'($urandom), 1'b0, o, e);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.dout_dp1, bus.dout_dp2, bus.dout_chn, bus.sync_out} !== 41'd0)
         $display("FAIL reset_async: got dp1=%0d dp2=%0d chn=%0d sync=%0d want 0",
                  bus.dout_dp1, bus.dout_dp2, bus.dout_chn, bus.sync_out);
      else passed++;
      cur_tag = 61;
      foreach (pipe[i]) pipe[i] = zero_smp();
      exp_ochn = 8'd0;
      for (int n = 21; n < 24; n++) step(8'(n), 16'sd0, 1'b1, o, e);
      @(posedge clk); #1 rst_n = 1'b1;
      cur_tag = 62;
      for (int n = 24; n < 24 + 9*256; n++) begin
         c = n % 256;
         step(8'(c), 16'sd0, 1'b0, o, e);
         checks++;
         if (o.chn !== e.chn || o.sync !== e.sync ||
             (e.tag == 61 && (o.dp1 !== 16'sd0 || o.dp2 !== 16'sd0)))
            $display("FAIL reset_resume: got chn=%0d dp1=%0d dp2=%0d want chn=%0d",
                     o.chn, o.dp1, o.dp2, e.chn);
         else passed++;
      end
      cur_tag = 63;
      for (int n = 0; n < 256 + 6; n++) begin
         c = (n + 24) % 256;
         step(8'(c), 16'($urandom), 1'b0, o, e);
         if (e.tag == 63) begin
            checks++;
            if (o.dp1 !== e.dp1 || o.dp2 !== e.dp2 || o.chn !== e.chn)
               $display("FAIL reset_data ch%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                        e.ichn, o.dp1, o.dp2, o.chn, e.dp1, e.dp2, e.chn);
            else passed++;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      bus.din_dq = 16'sd0;
      bus.din_chn = 8'd255;
      bus.sync_in = 1'b0;
      for (int i = 0; i < 337; i++) line.push_back(16'sd0);
      for (int i = 0; i < 6; i++) pipe.push_back(zero_smp());
      test_reset();
      test_impulse();
      test_dc();
      test_sat();
      test_gating();
      test_sync();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
